// File: rtl/signed_seq_divider.sv
// Iterative signed divider (truncating, C semantics), one restoring step per clock.
// Optional remainder output enabled by defining SDIV_REM_EN.
module signed_seq_divider #(
  parameter int unsigned N_W = 16,
  parameter int unsigned D_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N_W-1:0] dividend,
  input  logic signed [D_W-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [N_W-1:0] quot,
`ifdef SDIV_REM_EN
  output logic signed [D_W-1:0] rem,
`endif
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int unsigned CntW = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [N_W-1:0] NMin = {1'b1, {(N_W-1){1'b0}}};
  localparam logic [N_W-1:0] NMax = {1'b0, {(N_W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [N_W-1:0]  n_q;      // dividend magnitude, shifted out MSB first
  logic [N_W-1:0]  q_q;      // quotient magnitude, shifted in LSB first
  logic [D_W:0]    pr_q;     // partial remainder
  logic [D_W-1:0]  dmag_q;
  logic            sgn_n_q;
  logic            sgn_d_q;

  logic [N_W-1:0]  dvd_raw;
  logic [D_W-1:0]  dvs_raw;
  logic [N_W-1:0]  dvd_mag;
  logic [D_W-1:0]  dvs_mag;
  logic            is_zero;
  logic            is_ovf;
  logic [D_W:0]    shifted;
  logic [D_W+1:0]  trial;
  logic            qbit;
  logic [D_W:0]    pr_d;

  always_comb begin
    dvd_raw = dividend;
    dvs_raw = divisor;
    dvd_mag = dvd_raw[N_W-1] ? (~dvd_raw) + N_W'(1) : dvd_raw;
    dvs_mag = dvs_raw[D_W-1] ? (~dvs_raw) + D_W'(1) : dvs_raw;
    is_zero = (dvs_raw == '0);
    is_ovf  = (dvd_raw == NMin) && (dvs_raw == '1);
  end

  // pr_q < |divisor| always holds, so its low D_W bits carry the full value.
  always_comb begin
    shifted = {pr_q[D_W-1:0], n_q[N_W-1]};
    trial   = {1'b0, shifted} - {2'b00, dmag_q};
    qbit    = ~trial[D_W+1];
    pr_d    = qbit ? trial[D_W:0] : shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
`ifdef SDIV_REM_EN
      rem       <= '0;
`endif
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      cnt_q     <= '0;
      n_q       <= '0;
      q_q       <= '0;
      pr_q      <= '0;
      dmag_q    <= '0;
      sgn_n_q   <= 1'b0;
      sgn_d_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            n_q      <= dvd_mag;
            dmag_q   <= dvs_mag;
            sgn_n_q  <= dvd_raw[N_W-1];
            sgn_d_q  <= dvs_raw[D_W-1];
            pr_q     <= '0;
            q_q      <= '0;
            in_ready <= 1'b0;
            if (is_zero) begin
              quot      <= dvd_raw[N_W-1] ? NMin : NMax;
`ifdef SDIV_REM_EN
              rem       <= dvd_raw[D_W-1:0];
`endif
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else if (is_ovf) begin
              quot      <= NMax;
`ifdef SDIV_REM_EN
              rem       <= '0;
`endif
              div_zero  <= 1'b0;
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              cnt_q   <= CntW'(N_W - 1);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          pr_q  <= pr_d;
          n_q   <= {n_q[N_W-2:0], 1'b0};
          q_q   <= {q_q[N_W-2:0], qbit};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          quot      <= (sgn_n_q ^ sgn_d_q) ? (~q_q) + N_W'(1) : q_q;
`ifdef SDIV_REM_EN
          rem       <= sgn_n_q ? (~pr_q[D_W-1:0]) + D_W'(1) : pr_q[D_W-1:0];
`endif
          div_zero  <= 1'b0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider (16/8); remainder checks follow SDIV_REM_EN.
module tb_signed_seq_divider;

  localparam int unsigned N_W = 16;
  localparam int unsigned D_W = 8;
  localparam int NormLat = N_W + 2;  // edges counted including the accepting edge

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [N_W-1:0] dividend;
  logic signed [D_W-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N_W-1:0] quot;
`ifdef SDIV_REM_EN
  logic signed [D_W-1:0] rem;
`endif
  logic                  div_zero;
  logic                  ovf;

  typedef struct {
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic signed [63:0] dz;
    logic signed [63:0] ov;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  signed_seq_divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
`ifdef SDIV_REM_EN
    .rem      (rem),
`endif
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic signed [N_W-1:0] a, input logic signed [D_W-1:0] b);
    exp_t e;
    logic signed [D_W-1:0] low;
    int ai;
    int bi;
    ai = a;
    bi = b;
    low = a[D_W-1:0];
    e.dz = 0;
    e.ov = 0;
    e.lat = 1;
    if (bi == 0) begin
      e.q  = (ai >= 0) ? 32767 : -32768;
      e.r  = low;
      e.dz = 1;
    end else if (ai == -32768 && bi == -1) begin
      e.q  = 32767;
      e.r  = 0;
      e.ov = 1;
    end else begin
      e.q   = ai / bi;
      e.r   = ai % bi;
      e.lat = NormLat;
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_quot"}, quot, 0);
`ifdef SDIV_REM_EN
    check_val({tag, "_rem"}, rem, 0);
`endif
    check_val({tag, "_div_zero"}, div_zero, 0);
    check_val({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic run_op(input logic signed [N_W-1:0] a, input logic signed [D_W-1:0] b,
                        input int hold);
    exp_t e;
    int   edges;
    int   busy_bad;
    int   good;
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    e = model(a, b);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = N_W'($urandom);
    divisor  = D_W'($urandom);
    edges    = 1;
    busy_bad = 0;
    while (!out_valid && edges < 100) begin
      if (in_ready) busy_bad++;
      @(negedge clk);
      edges++;
    end
    check_val("latency", edges, e.lat);
    check_val("in_ready_busy", busy_bad, 0);
    good = 0;
    for (int i = 0; i < hold; i++) begin
      if (out_valid && !in_ready && quot == e.q && div_zero == e.dz[0] && ovf == e.ov[0])
        good++;
      @(negedge clk);
    end
    if (hold > 0) check_val("bp_stable", good, hold);
    e = sb.pop_front();
    check_val("out_valid", out_valid, 1);
    check_val("in_ready_done", in_ready, 0);
    check_val("quot", quot, e.q);
`ifdef SDIV_REM_EN
    check_val("rem", rem, e.r);
`endif
    check_val("div_zero", div_zero, e.dz);
    check_val("ovf", ovf, e.ov);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("out_valid_drop", out_valid, 0);
    check_val("in_ready_back", in_ready, 1);
    check_val("quot_hold", quot, e.q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_op(-100, 7, 0);
    run_op(100, -7, 0);
    run_op(1000, -8, 0);
    run_op(5, 0, 0);
    run_op(-9, 0, 0);
    run_op(-16'sd32768, -1, 0);
    run_op(-16'sd32768, -128, 0);
    run_op(32767, 127, 0);
    run_op(-16'sd32768, 1, 0);
    run_op(1234, -56, 10);

    // Abort an operation five cycles into the iteration.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = -5000;
    divisor  = 9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    run_op(77, 3, 0);

    for (int i = 0; i < 6; i++) begin
      logic signed [N_W-1:0] ra;
      logic signed [D_W-1:0] rb;
      ra = N_W'($urandom);
      rb = D_W'($urandom);
      run_op(ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
